uart_iram_loader: RTL and testbench

Receives a byte stream from the UART receive FIFO, packs byte pairs (high byte first) into 16-bit instruction words and writes them sequentially into the microcontroller's instruction RAM through its `iram_wa`/`iram_wen`/`iram_din` port. It sits between the `uart` receive side and `micro`. While a load is in progress it holds the CPU with `cpu_hold`. It recovers from a lost byte with an inter-byte timeout, and ends a load on a full memory or on an idle line.

---
 rtl/uart_iram_loader.sv | 151 +++++++++++++++
 tb/tb_uart_iram_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_iram_loader.sv
// Bootloader bridge: pops bytes from the UART RX FIFO, packs them high-byte-first
// into 16-bit words and writes them sequentially into the instruction RAM.
module uart_iram_loader #(
  parameter int unsigned IRAM_ADDR_BITS = 8,
  parameter int unsigned RD_GAP         = 10,
  parameter int unsigned TIMEOUT        = 1_000_000
) (
  input  logic                      clk_100MHz,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic                      rx_empty,
  input  logic [7:0]                rx_data,
  output logic                      rd_uart,
  output logic [IRAM_ADDR_BITS-1:0] iram_wa,
  output logic                      iram_wen,
  output logic [15:0]               iram_din,
  output logic                      cpu_hold,
  output logic                      done,
  output logic [IRAM_ADDR_BITS:0]   word_cnt,
  output logic                      sync_err
);

  localparam int unsigned CNT_W  = IRAM_ADDR_BITS + 1;
  localparam int unsigned GAP_W  = (RD_GAP < 1) ? 1 : $clog2(RD_GAP + 1);
  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                    state;
  logic [GAP_W-1:0]          gap_cnt;
  logic [IDLE_W-1:0]         idle_cnt;
  logic [IRAM_ADDR_BITS-1:0] addr;
  logic [7:0]                hi_byte;

  logic waiting;
  logic pop;
  logic timeout;

  // Pop only after rx_empty has been low long enough for the FIFO head to settle.
  assign waiting = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);
  assign pop     = waiting && !rx_empty && (gap_cnt == GAP_W'(RD_GAP));
  assign timeout = !pop && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state    <= ST_IDLE;
      gap_cnt  <= '0;
      idle_cnt <= '0;
      addr     <= '0;
      hi_byte  <= '0;
      rd_uart  <= 1'b0;
      iram_wa  <= '0;
      iram_wen <= 1'b0;
      iram_din <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      rd_uart  <= pop;
      iram_wen <= 1'b0;

      if (waiting && !rx_empty && !pop) gap_cnt <= gap_cnt + GAP_W'(1);
      else                              gap_cnt <= '0;

      // Saturates so an empty load can wait forever without wrapping.
      if (!waiting || pop)                      idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(TIMEOUT))    idle_cnt <= idle_cnt + IDLE_W'(1);

      case (state)
        ST_IDLE: begin
          cpu_hold <= 1'b0;
          done     <= 1'b0;
          if (load_en) begin
            word_cnt <= '0;
            sync_err <= 1'b0;
            addr     <= '0;
            cpu_hold <= 1'b1;
            state    <= ST_WAIT_HI;
          end
        end

        ST_WAIT_HI: begin
          if (!load_en) begin
            cpu_hold <= 1'b0;
            state    <= ST_IDLE;
          end else if (pop) begin
            hi_byte <= rx_data;
            state   <= ST_WAIT_LO;
          end else if (timeout && (word_cnt != '0)) begin
            cpu_hold <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end

        ST_WAIT_LO: begin
          if (!load_en) begin
            cpu_hold <= 1'b0;
            state    <= ST_IDLE;
          end else if (pop) begin
            iram_wen <= 1'b1;
            iram_din <= {hi_byte, rx_data};
            iram_wa  <= addr;
            state    <= ST_WRITE;
          end else if (timeout) begin
            // Lost low byte: drop the half word and resynchronise on the next byte.
            sync_err <= 1'b1;
            idle_cnt <= '0;
            state    <= ST_WAIT_HI;
          end
        end

        ST_WRITE: begin
          addr     <= addr + IRAM_ADDR_BITS'(1);
          word_cnt <= word_cnt + CNT_W'(1);
          if (!load_en) begin
            cpu_hold <= 1'b0;
            state    <= ST_IDLE;
          end else if (addr == '1) begin
            cpu_hold <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_WAIT_HI;
          end
        end

        ST_DONE: begin
          if (!load_en) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          cpu_hold <= 1'b0;
          done     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_iram_loader.sv
// Directed bench for uart_iram_loader: a FIFO model feeds bytes, a scoreboard
// checks every IRAM write against a queue of expected address/data pairs.
module tb_uart_iram_loader;

  localparam int unsigned AB  = 2;
  localparam int unsigned GAP = 10;
  localparam int unsigned TO  = 200;

  typedef struct {
    logic [AB-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic          clk_100MHz = 1'b0;
  logic          rst        = 1'b1;
  logic          load_en    = 1'b0;
  logic          rx_empty   = 1'b1;
  logic [7:0]    rx_data    = 8'h00;
  logic          rd_uart;
  logic [AB-1:0] iram_wa;
  logic          iram_wen;
  logic [15:0]   iram_din;
  logic          cpu_hold;
  logic          done;
  logic [AB:0]   word_cnt;
  logic          sync_err;

  logic [7:0] fifo[$];
  logic       hide = 1'b0;
  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;

  uart_iram_loader #(.IRAM_ADDR_BITS(AB), .RD_GAP(GAP), .TIMEOUT(TO)) dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .load_en(load_en),
    .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_uart),
    .iram_wa(iram_wa), .iram_wen(iram_wen), .iram_din(iram_din),
    .cpu_hold(cpu_hold), .done(done), .word_cnt(word_cnt), .sync_err(sync_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: pops on rd_uart, updates its outputs just after the falling edge.
  always @(negedge clk_100MHz) begin
    #1;
    if (rd_uart === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
    rx_empty = (fifo.size() == 0) || hide;
    rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // Scoreboard monitor for IRAM writes.
  always @(negedge clk_100MHz) begin
    if (iram_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", iram_wa, iram_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(iram_wa), 32'(e.addr));
        check("wr_data", 32'(iram_din), 32'(e.data));
      end
    end
  end

  task automatic expect_wr(input logic [AB-1:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_uart"}, 32'(rd_uart), 0);
    check({tag, "_iram_wen"}, 32'(iram_wen), 0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_sync_err"}, 32'(sync_err), 0);
    check({tag, "_iram_wa"}, 32'(iram_wa), 0);
    check({tag, "_iram_din"}, 32'(iram_din), 0);
    check({tag, "_word_cnt"}, 32'(word_cnt), 0);
  endtask

  task automatic wait_rd(input string name, input int budget);
    int n = 0;
    while (rd_uart !== 1'b1 && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    check(name, 32'(rd_uart), 1);
  endtask

  task automatic wait_wen(input string name, input int budget);
    int n = 0;
    while (iram_wen !== 1'b1 && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    check(name, 32'(iram_wen), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    check(name, 32'(done), 1);
  endtask

  task automatic wait_cnt(input string name, input int val, input int budget);
    int n = 0;
    while (32'(word_cnt) != val && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    check(name, 32'(word_cnt), 32'(val));
  endtask

  // Watches rd_uart for n falling edges; returns first index seen high and pulse count.
  task automatic watch_rd(input int n, input int hide_on, input int hide_off,
                          output int first, output int count);
    first = -1;
    count = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_100MHz);
      if (i == hide_on) hide = 1'b1;
      if (i == hide_off) hide = 1'b0;
      if (rd_uart === 1'b1) begin
        count++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int first;
    int count;

    cycles(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    cycles(2);

    // Basic load of two words, then finish on the idle timeout.
    load_en = 1'b1;
    @(negedge clk_100MHz);
    check("basic_hold_rise", 32'(cpu_hold), 1);
    expect_wr(2'd0, 16'h1234);
    expect_wr(2'd1, 16'hABCD);
    fifo.push_back(8'h12); fifo.push_back(8'h34);
    fifo.push_back(8'hAB); fifo.push_back(8'hCD);
    wait_cnt("basic_word_cnt", 2, 200);
    check("basic_hold_busy", 32'(cpu_hold), 1);
    wait_done("basic_done", 2 * TO + 50);
    check("basic_hold_done", 32'(cpu_hold), 0);
    check("basic_final_cnt", 32'(word_cnt), 2);
    check("basic_wa_hold", 32'(iram_wa), 1);
    check("basic_din_hold", 32'(iram_din), 32'h0000ABCD);
    load_en = 1'b0;
    cycles(2);
    check("basic_done_clr", 32'(done), 0);

    // Gap timing: pop exactly RD_GAP cycles after rx_empty falls; a glitch restarts it.
    load_en = 1'b1;
    cycles(3);
    fifo.push_back(8'h77);
    watch_rd(15, 0, 0, first, count);
    check("gap_first_pop", 32'(first), 11);
    check("gap_pulse_count", 32'(count), 1);
    expect_wr(2'd0, 16'h7788);
    fifo.push_back(8'h88);
    watch_rd(25, 5, 6, first, count);
    check("gap_restart_pop", 32'(first), 17);
    check("gap_restart_count", 32'(count), 1);
    check("gap_word_cnt", 32'(word_cnt), 1);
    load_en = 1'b0;
    cycles(2);

    // Lost byte: a lone high byte is discarded after the inter-byte timeout.
    load_en = 1'b1;
    cycles(2);
    fifo.push_back(8'h55);
    wait_rd("lost_pop", 40);
    cycles(TO + 30);
    check("lost_sync_err", 32'(sync_err), 1);
    check("lost_word_cnt", 32'(word_cnt), 0);
    check("lost_hold", 32'(cpu_hold), 1);
    expect_wr(2'd0, 16'h0102);
    fifo.push_back(8'h01); fifo.push_back(8'h02);
    wait_cnt("lost_resync_cnt", 1, 100);
    load_en = 1'b0;
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    check("lost_abort_hold", 32'(cpu_hold), 0);
    check("lost_abort_done", 32'(done), 0);

    // Abort while waiting for the low byte.
    load_en = 1'b1;
    cycles(2);
    fifo.push_back(8'h99);
    wait_rd("abort_hi_pop", 40);
    load_en = 1'b0;
    @(negedge clk_100MHz);
    check("abort_hold", 32'(cpu_hold), 0);
    check("abort_done", 32'(done), 0);
    check("abort_word_cnt", 32'(word_cnt), 0);
    cycles(20);

    // Full memory: 10 bytes, only 4 words fit, 2 bytes left behind.
    load_en = 1'b1;
    cycles(2);
    expect_wr(2'd0, 16'h0001);
    expect_wr(2'd1, 16'h0203);
    expect_wr(2'd2, 16'h0405);
    expect_wr(2'd3, 16'h0607);
    for (int b = 0; b < 10; b++) fifo.push_back(8'(b));
    wait_done("full_done", 600);
    check("full_word_cnt", 32'(word_cnt), 4);
    check("full_hold", 32'(cpu_hold), 0);
    watch_rd(60, 0, 0, first, count);
    check("full_no_pop", 32'(count), 0);
    check("full_fifo_left", 32'(fifo.size()), 2);
    load_en = 1'b0;
    @(negedge clk_100MHz);
    check("full_done_clr", 32'(done), 0);
    fifo.delete();
    cycles(3);

    // Reset during WRITE, then a fresh load restarts at address 0.
    load_en = 1'b1;
    cycles(2);
    expect_wr(2'd0, 16'hDEAD);
    fifo.push_back(8'hDE); fifo.push_back(8'hAD);
    wait_wen("rst_write_seen", 100);
    rst = 1'b1;
    @(negedge clk_100MHz);
    check_reset_outputs("midrst");
    rst = 1'b0;
    expect_wr(2'd0, 16'hBEEF);
    fifo.push_back(8'hBE); fifo.push_back(8'hEF);
    wait_cnt("rst_restart_cnt", 1, 100);
    load_en = 1'b0;
    cycles(3);

    check("writes_outstanding", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
